// File: rtl/terminal_ctrl.sv
// Text terminal controller: turns PS/2 ASCII/scancode strobes into character
// buffer writes, manages the cursor, and runs screen / line clear sweeps.
module terminal_ctrl #(
  parameter int CHAR_HORZ_CNT = 80,
  parameter int CHAR_VERT_CNT = 25,
  parameter int CHAR_HORZ_W   = $clog2(CHAR_HORZ_CNT),
  parameter int CHAR_VERT_W   = $clog2(CHAR_VERT_CNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ps2_ascii_vld,
  input  logic [7:0]             ps2_ascii,
  input  logic                   ps2_scancode_vld,
  input  logic [7:0]             ps2_scancode,
  output logic [CHAR_HORZ_W-1:0] char_hpos,
  output logic [CHAR_VERT_W-1:0] char_vpos,
  output logic                   char_write_en,
  output logic [7:0]             char_symbol,
  output logic [CHAR_HORZ_W-1:0] cursor_hpos,
  output logic [CHAR_VERT_W-1:0] cursor_vpos,
  output logic                   busy
);

  localparam logic [CHAR_HORZ_W-1:0] H_LAST = CHAR_HORZ_W'(CHAR_HORZ_CNT - 1);
  localparam logic [CHAR_VERT_W-1:0] V_LAST = CHAR_VERT_W'(CHAR_VERT_CNT - 1);

  typedef enum logic [1:0] {CLEAR_ALL, CLEAR_LINE, IDLE} state_t;

  state_t                 state;
  logic [CHAR_HORZ_W-1:0] clr_h;
  logic [CHAR_VERT_W-1:0] clr_v;
  logic [CHAR_VERT_W-1:0] next_row;

  assign next_row = (cursor_vpos == V_LAST) ? '0 : cursor_vpos + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= CLEAR_ALL;
      clr_h         <= '0;
      clr_v         <= '0;
      cursor_hpos   <= '0;
      cursor_vpos   <= '0;
      char_hpos     <= '0;
      char_vpos     <= '0;
      char_symbol   <= 8'h20;
      char_write_en <= 1'b0;
      busy          <= 1'b1;
    end else begin
      char_write_en <= 1'b0;
      // busy trails the state by one cycle so it lines up with the clear writes
      busy          <= (state != IDLE);
      case (state)
        CLEAR_ALL: begin
          char_write_en <= 1'b1;
          char_symbol   <= 8'h20;
          char_hpos     <= clr_h;
          char_vpos     <= clr_v;
          if (clr_h == H_LAST) begin
            clr_h <= '0;
            if (clr_v == V_LAST) begin
              clr_v <= '0;
              state <= IDLE;
            end else begin
              clr_v <= clr_v + 1'b1;
            end
          end else begin
            clr_h <= clr_h + 1'b1;
          end
        end
        CLEAR_LINE: begin
          char_write_en <= 1'b1;
          char_symbol   <= 8'h20;
          char_hpos     <= clr_h;
          char_vpos     <= clr_v;
          if (clr_h == H_LAST) begin
            clr_h <= '0;
            state <= IDLE;
          end else begin
            clr_h <= clr_h + 1'b1;
          end
        end
        IDLE: begin
          // the cycle that still shows busy high is also dead for input
          if (!busy && ps2_ascii_vld) begin
            if (ps2_ascii >= 8'h20 && ps2_ascii <= 8'h7E) begin
              char_write_en <= 1'b1;
              char_symbol   <= ps2_ascii;
              char_hpos     <= cursor_hpos;
              char_vpos     <= cursor_vpos;
              if (cursor_hpos == H_LAST) begin
                cursor_hpos <= '0;
                cursor_vpos <= next_row;
                clr_h       <= '0;
                clr_v       <= next_row;
                state       <= CLEAR_LINE;
              end else begin
                cursor_hpos <= cursor_hpos + 1'b1;
              end
            end else begin
              case (ps2_ascii)
                8'h0D, 8'h0A: begin
                  cursor_hpos <= '0;
                  cursor_vpos <= next_row;
                  clr_h       <= '0;
                  clr_v       <= next_row;
                  state       <= CLEAR_LINE;
                end
                8'h08: begin
                  if (cursor_hpos != '0) begin
                    cursor_hpos   <= cursor_hpos - 1'b1;
                    char_hpos     <= cursor_hpos - 1'b1;
                    char_vpos     <= cursor_vpos;
                    char_symbol   <= 8'h20;
                    char_write_en <= 1'b1;
                  end else if (cursor_vpos != '0) begin
                    cursor_hpos   <= H_LAST;
                    cursor_vpos   <= cursor_vpos - 1'b1;
                    char_hpos     <= H_LAST;
                    char_vpos     <= cursor_vpos - 1'b1;
                    char_symbol   <= 8'h20;
                    char_write_en <= 1'b1;
                  end
                end
                8'h1B: begin
                  cursor_hpos <= '0;
                  cursor_vpos <= '0;
                  clr_h       <= '0;
                  clr_v       <= '0;
                  state       <= CLEAR_ALL;
                end
                default: ;
              endcase
            end
          end else if (!busy && ps2_scancode_vld) begin
            case (ps2_scancode)
              8'h6B: if (cursor_hpos != '0)     cursor_hpos <= cursor_hpos - 1'b1;
              8'h74: if (cursor_hpos != H_LAST) cursor_hpos <= cursor_hpos + 1'b1;
              8'h75: if (cursor_vpos != '0)     cursor_vpos <= cursor_vpos - 1'b1;
              8'h72: if (cursor_vpos != V_LAST) cursor_vpos <= cursor_vpos + 1'b1;
              default: ;
            endcase
          end
        end
        default: state <= CLEAR_ALL;
      endcase
    end
  end

endmodule

// File: tb/tb_terminal_ctrl.sv
// Directed bench for terminal_ctrl: clears, typing, wrap, backspace,
// cursor keys, dropped strobes while busy, and reset mid-sweep.
module tb_terminal_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_ascii_vld = 1'b0;
  logic [7:0] ps2_ascii = 8'h00;
  logic       ps2_scancode_vld = 1'b0;
  logic [7:0] ps2_scancode = 8'h00;
  logic [6:0] char_hpos;
  logic [4:0] char_vpos;
  logic       char_write_en;
  logic [7:0] char_symbol;
  logic [6:0] cursor_hpos;
  logic [4:0] cursor_vpos;
  logic       busy;

  int errors = 0;
  int checks = 0;

  terminal_ctrl dut (
    .clk(clk), .rst(rst),
    .ps2_ascii_vld(ps2_ascii_vld), .ps2_ascii(ps2_ascii),
    .ps2_scancode_vld(ps2_scancode_vld), .ps2_scancode(ps2_scancode),
    .char_hpos(char_hpos), .char_vpos(char_vpos),
    .char_write_en(char_write_en), .char_symbol(char_symbol),
    .cursor_hpos(cursor_hpos), .cursor_vpos(cursor_vpos), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_ascii(input logic [7:0] c);
    ps2_ascii_vld = 1'b1;
    ps2_ascii     = c;
    tick;
    ps2_ascii_vld = 1'b0;
  endtask

  task automatic send_sc(input logic [7:0] c);
    ps2_scancode_vld = 1'b1;
    ps2_scancode     = c;
    tick;
    ps2_scancode_vld = 1'b0;
  endtask

  // Expects n write cycles of 0x20; row < 0 means row-major full screen
  task automatic sweep(input string tag, input int first, input int n, input int row);
    int bad = 0;
    int idx;
    logic [31:0] eh, ev;
    for (int i = 0; i < n; i++) begin
      tick;
      idx = first + i;
      if (row < 0) begin eh = idx % 80; ev = idx / 80; end
      else begin eh = idx; ev = row; end
      if (!(char_write_en === 1'b1 && {25'd0, char_hpos} === eh &&
            {27'd0, char_vpos} === ev && char_symbol === 8'h20 && busy === 1'b1))
        bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic chk_cursor(input string tag, input int h, input int v);
    chk(tag, {cursor_vpos, cursor_hpos}, {v[4:0], h[6:0]});
  endtask

  task automatic chk_write(input string tag, input logic [7:0] s, input int h, input int v);
    chk(tag, {char_write_en, char_symbol, char_vpos, char_hpos},
        {1'b1, s, v[4:0], h[6:0]});
  endtask

  initial begin
    // reset state
    tick; tick;
    chk("rst_busy", busy, 1);
    chk("rst_we", char_write_en, 0);
    chk("rst_sym", char_symbol, 8'h20);
    chk("rst_pos", {char_vpos, char_hpos}, 0);
    chk_cursor("rst_cursor", 0, 0);
    rst = 1'b0;

    // power-up clear
    sweep("init_sweep", 0, 2000, -1);
    tick;
    chk("init_busy_fall", busy, 0);
    chk("init_we_low", char_write_en, 0);
    chk_cursor("init_cursor", 0, 0);

    // first character
    send_ascii(8'h41);
    chk_write("wr_A", 8'h41, 0, 0);
    chk_cursor("cur_after_A", 1, 0);
    chk("busy_after_A", busy, 0);
    tick;
    chk("we_pulse_1cyc", char_write_en, 0);

    // cursor keys saturate at the bottom-right corner
    for (int i = 0; i < 80; i++) send_sc(8'h74);
    for (int i = 0; i < 30; i++) send_sc(8'h72);
    chk_cursor("sat_br", 79, 24);
    chk("sc_no_write", char_write_en, 0);

    // last cell wraps to row 0 and clears it; strobes during clear dropped
    send_ascii(8'h42);
    chk_write("wr_B_last", 8'h42, 79, 24);
    chk_cursor("wrap_cursor", 0, 0);
    begin
      int bad = 0;
      for (int i = 0; i < 80; i++) begin
        tick;
        if (!(char_write_en === 1'b1 && char_hpos === 7'(i) && char_vpos === 5'd0 &&
              char_symbol === 8'h20 && busy === 1'b1 && cursor_hpos === 7'd0 &&
              cursor_vpos === 5'd0))
          bad++;
        ps2_ascii_vld    = (i == 10) || (i == 30);
        ps2_ascii        = (i == 10) ? 8'h1B : 8'h58;
        ps2_scancode_vld = (i == 20);
        ps2_scancode     = 8'h72;
      end
      chk("line_clear_row0", bad, 0);
    end
    ps2_ascii_vld = 1'b0; ps2_scancode_vld = 1'b0;
    tick;
    chk("line_busy_fall", busy, 0);
    chk("line_we_low", char_write_en, 0);
    chk_cursor("line_cursor_kept", 0, 0);

    // backspace across a row boundary
    for (int i = 0; i < 3; i++) send_sc(8'h72);
    chk_cursor("at_0_3", 0, 3);
    send_ascii(8'h08);
    chk_write("bs_wrap_wr", 8'h20, 79, 2);
    chk_cursor("bs_wrap_cur", 79, 2);
    send_sc(8'h75); send_sc(8'h75);
    for (int i = 0; i < 80; i++) send_sc(8'h6B);
    chk_cursor("at_0_0", 0, 0);
    send_ascii(8'h08);
    chk("bs_00_no_we", char_write_en, 0);
    chk_cursor("bs_00_cur", 0, 0);
    send_ascii(8'h5A);
    send_ascii(8'h08);
    chk_write("bs_mid_wr", 8'h20, 0, 0);
    chk_cursor("bs_mid_cur", 0, 0);

    // edge saturation and ascii-over-scancode priority
    send_sc(8'h6B);
    send_sc(8'h75);
    chk_cursor("sat_tl", 0, 0);
    send_sc(8'h72);
    chk_cursor("down_1", 0, 1);
    ps2_scancode_vld = 1'b1; ps2_scancode = 8'h74;
    send_ascii(8'h43);
    ps2_scancode_vld = 1'b0;
    chk_write("both_wr_C", 8'h43, 0, 1);
    chk_cursor("both_cur", 1, 1);
    tick;
    chk("hold_outputs", {char_write_en, char_symbol, char_vpos, char_hpos},
        {1'b0, 8'h43, 5'd1, 7'd0});

    // unknown code ignored
    send_ascii(8'h07);
    chk("ign_no_we", char_write_en, 0);
    chk_cursor("ign_cur", 1, 1);

    // newline clears the next row
    send_ascii(8'h0D);
    chk_cursor("nl_cur", 0, 2);
    chk("nl_no_we", char_write_en, 0);
    sweep("nl_clear_row2", 0, 80, 2);
    tick;
    chk("nl_busy_fall", busy, 0);

    // clear screen
    send_ascii(8'h0A);
    sweep("lf_clear_row3", 0, 80, 3);
    tick;
    chk_cursor("lf_cur", 0, 3);
    send_ascii(8'h1B);
    chk_cursor("esc_cur", 0, 0);
    sweep("esc_sweep", 0, 2000, -1);
    tick;
    chk("esc_busy_fall", busy, 0);

    // reset mid-sweep restarts from (0,0)
    send_ascii(8'h1B);
    sweep("pre_rst_sweep", 0, 50, -1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 1);
    chk("midrst_we", char_write_en, 0);
    tick;
    rst = 1'b0;
    sweep("restart_sweep", 0, 2000, -1);
    tick;
    chk("restart_busy_fall", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/terminal_ctrl.md
TERMINAL_CTRL -- requirements
Module: terminal_ctrl

Interface
REQ-001 SHALL have parameter CHAR_HORZ_CNT, default 80, meaning text columns.
REQ-002 SHALL have parameter CHAR_VERT_CNT, default 25, meaning text rows.
REQ-003 SHALL have parameter CHAR_HORZ_W, default $clog2(CHAR_HORZ_CNT), meaning column index width.
REQ-004 SHALL have parameter CHAR_VERT_W, default $clog2(CHAR_VERT_CNT), meaning row index width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port ps2_ascii_vld, input, 1, one-cycle strobe qualifying ps2_ascii.
REQ-008 SHALL have port ps2_ascii, input, 8, ASCII code of the key.
REQ-009 SHALL have port ps2_scancode_vld, input, 1, one-cycle strobe qualifying ps2_scancode.
REQ-010 SHALL have port ps2_scancode, input, 8, PS/2 set-2 scancode.
REQ-011 SHALL have port char_hpos, output, CHAR_HORZ_W, character buffer write column.
REQ-012 SHALL have port char_vpos, output, CHAR_VERT_W, character buffer write row.
REQ-013 SHALL have port char_write_en, output, 1, character buffer write strobe.
REQ-014 SHALL have port char_symbol, output, 8, character code to write.
REQ-015 SHALL have port cursor_hpos, output, CHAR_HORZ_W, cursor column.
REQ-016 SHALL have port cursor_vpos, output, CHAR_VERT_W, cursor row.
REQ-017 SHALL have port busy, output, 1, high while a screen or line clear is in progress.

Function
REQ-018 SHALL implement states CLEAR_ALL, CLEAR_LINE, IDLE; all outputs registered.
REQ-019 SHALL, in IDLE, act on ps2_ascii_vld; if ps2_ascii_vld and ps2_scancode_vld are high together, the scancode is dropped.
REQ-020 SHALL, for printable ASCII 0x20-0x7E, pulse char_write_en for exactly one cycle, the cycle after the strobe, with char_symbol = code at the old cursor position, and advance cursor_hpos in the same cycle.
REQ-021 SHALL, when a printable character is written at column CHAR_HORZ_CNT-1, set the cursor to column 0 of the next row (row CHAR_VERT_CNT-1 wraps to row 0) and enter CLEAR_LINE for that row.
REQ-022 SHALL treat 0x0D and 0x0A as newline: cursor to column 0 of next row (same wrap), then CLEAR_LINE for that row.
REQ-023 SHALL treat 0x08 as backspace: column>0 -> column-1; column 0 and row>0 -> (CHAR_HORZ_CNT-1, row-1); then write 0x20 at the new position one cycle after the strobe; at (0,0) no write and no cursor change.
REQ-024 SHALL treat 0x1B as clear screen: cursor to (0,0), enter CLEAR_ALL.
REQ-025 SHALL ignore all other ASCII codes (no write, no cursor change).
REQ-026 SHALL, in IDLE with no ascii strobe, move the cursor on scancodes 0x6B left, 0x74 right, 0x75 up, 0x72 down, saturating at edges (no wrap, no write, no line clear).
REQ-027 SHALL, in CLEAR_ALL, write 0x20 once per cycle in row-major order (0,0), (1,0) ... (CHAR_HORZ_CNT-1, CHAR_VERT_CNT-1), CHAR_HORZ_CNT*CHAR_VERT_CNT consecutive write cycles, then go to IDLE.
REQ-028 SHALL, in CLEAR_LINE, write 0x20 to columns 0..CHAR_HORZ_CNT-1 of the target row on CHAR_HORZ_CNT consecutive cycles starting the cycle after entry, then go to IDLE.
REQ-029 SHALL hold busy high in CLEAR_ALL and CLEAR_LINE; busy SHALL fall in the first IDLE cycle.
REQ-030 SHALL drop (not queue) all ascii and scancode strobes while busy.
REQ-031 SHALL keep char_write_en low in IDLE except for REQ-020 and REQ-023 pulses; char_hpos, char_vpos, char_symbol hold their last values when char_write_en is low.
REQ-032 SHALL keep cursor_hpos < CHAR_HORZ_CNT and cursor_vpos < CHAR_VERT_CNT at all times.

Reset
REQ-033 SHALL, while rst is high, force state CLEAR_ALL, clear counters 0, cursor (0,0), char_hpos 0, char_vpos 0, char_symbol 0x20, char_write_en 0, busy 1.
REQ-034 SHALL issue the first clear write (0,0) in the first clock edge after rst falls; rst asserted mid-clear SHALL restart the sweep from (0,0).

Verification
REQ-035 Reset release -> 2000 consecutive char_write_en cycles, symbol 0x20, addresses (0,0)..(79,24) row-major; busy falls next cycle; cursor (0,0).
REQ-036 After clear, ascii 0x41 strobe -> next cycle write 0x41 at (0,0), cursor (1,0), busy 0.
REQ-037 Cursor (79,24), ascii 0x42 -> write 0x42 at (79,24), cursor (0,0), then 80 writes of 0x20 on row 0, busy high for 80 cycles.
REQ-038 Cursor (0,3), ascii 0x08 -> cursor (79,2), write 0x20 at (79,2); at (0,0) 0x08 -> no write.
REQ-039 Cursor (0,0), scancode 0x6B then 0x75 -> cursor stays (0,0); 0x72 -> (0,1); simultaneous ascii 0x43 and scancode 0x74 -> only 0x43 written, cursor (1,1).
REQ-040 Strobes during CLEAR_LINE -> no writes, cursor unchanged; 0x1B -> cursor (0,0), full 2000-cycle sweep.
